stopwatch_cmd_fsm: RTL and testbench
====================================

Name: stopwatch_cmd_fsm

Overview:
Consumes the four debounced, active-high button levels (start, stop, load, reset_button) produced by the button debouncer. Converts them into press events and runs the stopwatch control state machine. Drives the run enable, single-cycle load and clear strobes, and the state code for the HEXACUBE counter/display datapath. Adds long-press auto-repeat on load for fast value entry. Clocked from the 50 MHz system clock.

Parameters:
LONG_PRESS_CYCLES, 50000000, cycles load must be held in LOAD state before auto-repeat starts (1 s at 50 MHz); legal range >= 2
REPEAT_CYCLES, 10000000, auto-repeat period in cycles (200 ms at 50 MHz); legal range >= 2
CNT_W, 26, hold/repeat counter width; requires 2^CNT_W > max(LONG_PRESS_CYCLES, REPEAT_CYCLES)

Ports:
clk  input  1  system clock, 50 MHz, all logic on posedge
reset  input  1  synchronous, active-high reset
btn_start  input  1  debounced start level, active high
btn_stop  input  1  debounced stop level, active high
btn_load  input  1  debounced load level, active high
btn_reset  input  1  debounced reset_button level, active high
run  output  1  registered level, high only in RUN
load_pulse  output  1  registered one-cycle strobe, increment/load preset value
clear_pulse  output  1  registered one-cycle strobe, clear stopwatch count
state  output  2  registered state code: IDLE=00, RUN=01, PAUSE=10, LOAD=11

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk.
- Reset: state=IDLE, run=0, load_pulse=0, clear_pulse=0, hold and repeat counters=0.
- Reset: the four prev-level registers are set to 1, so a button already held through reset produces no event.
- Edge detect: prev_x <= btn_x every cycle.
- Edge detect: press_x_q <= btn_x & ~prev_x, registered.
- Latency: input first sampled high at edge k sets press_x_q at edge k. The FSM acts at edge k+1, so outputs change 2 clocks after the input rise.
- Priority, when several press_x_q are high in one cycle: reset > stop > start > load. Only the winner acts; losers are discarded, not queued.
- A reset press in any state: next state=IDLE, clear_pulse=1 for one cycle, counters cleared. A reset press in IDLE still emits clear_pulse.
- IDLE: start -> RUN. load -> LOAD with load_pulse=1. stop is ignored.
- RUN: stop -> PAUSE. start and load are ignored.
- PAUSE: start -> RUN. load -> LOAD with load_pulse=1. stop is ignored.
- LOAD: each load press gives load_pulse=1 and stays in LOAD. start -> RUN. stop -> PAUSE.
- run = (next state == RUN), registered together with state.
- Hold counter, active only while state==LOAD and btn_load==1: counts up each cycle.
- Hold counter clears when btn_load==0, on any state change, or on reset. It saturates at LONG_PRESS_CYCLES-1.
- Auto-repeat start: on the cycle the hold counter reaches LONG_PRESS_CYCLES-1, load_pulse=1. The repeat counter then starts from 0.
- Auto-repeat: while still held, the repeat counter counts 0..REPEAT_CYCLES-1 and wraps. Each wrap issues load_pulse=1.
- Auto-repeat: releasing btn_load stops repeat immediately, with no trailing pulse.
- The hold count includes the cycle of the entry press. The entry press pulse is separate from the first repeat pulse.
- A long-press pulse and a fresh load press cannot coincide, since a press needs a rising level. If a start/stop/reset press coincides with a repeat expiry, the press wins and no load_pulse is issued.
- At most one of load_pulse and clear_pulse is high in any cycle. Each strobe is exactly one cycle wide.
- Reset asserted mid-operation, including during auto-repeat: the full reset values apply at the next edge.

Test Plan:
Bench parameters: LONG_PRESS_CYCLES=8, REPEAT_CYCLES=4.
- Reset, then btn_start pulsed high for 3 cycles -> 2 cycles after the rise: state=01, run=1; no strobes.
- From RUN, btn_stop rise, then btn_start rise 5 cycles later -> state 01->10 (run=0) -> 01 (run=1).
- From IDLE, btn_load held 20 cycles -> load_pulse at +2 (entry), then at hold count 7, then every 4 cycles while held. Release -> no further pulses; state stays 11.
- btn_reset, btn_stop and btn_start rise in the same cycle while in RUN -> state=00, clear_pulse=1 for exactly 1 cycle, run=0.
- btn_start held high through reset and released 10 cycles after reset deassertion -> no event; state stays 00.
- Assert reset during auto-repeat in LOAD -> next edge: state=00, all outputs 0. Re-pressing load restarts the hold count from 0.

Source files
------------

// File: rtl/stopwatch_cmd_fsm.sv
// -----------------------------------------------------------------------------
// stopwatch_cmd_fsm
//
// Stopwatch command state machine. Turns the four debounced button levels into
// registered press events, runs the IDLE/RUN/PAUSE/LOAD control FSM and drives
// the counter/display datapath controls. Holding load in LOAD auto-repeats the
// load strobe for fast value entry.
//
// Handshake / timing: there is no valid/ready handshake on this block. Button
// inputs are levels; a rising level is captured as a one-cycle press event on
// the edge that first samples it high, and the FSM acts on the following edge,
// so outputs move two clocks after the input rise. load_pulse and clear_pulse
// are registered single-cycle strobes and are never high together.
//
// Ports:
//   clk          system clock, all logic on posedge
//   reset        synchronous, active-high reset
//   btn_start    debounced start level, active high
//   btn_stop     debounced stop level, active high
//   btn_load     debounced load level, active high
//   btn_reset    debounced reset_button level, active high
//   run          registered level, high only in RUN
//   load_pulse   registered one-cycle strobe: increment/load preset value
//   clear_pulse  registered one-cycle strobe: clear stopwatch count
//   state        registered state code: IDLE=00, RUN=01, PAUSE=10, LOAD=11
// -----------------------------------------------------------------------------
module stopwatch_cmd_fsm #(
  parameter int LONG_PRESS_CYCLES = 50000000,
  parameter int REPEAT_CYCLES     = 10000000,
  parameter int CNT_W             = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       btn_load,
  input  logic       btn_reset,
  output logic       run,
  output logic       load_pulse,
  output logic       clear_pulse,
  output logic [1:0] state
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
  localparam logic [1:0] ST_LOAD  = 2'b11;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_PRE  = CNT_W'(LONG_PRESS_CYCLES - 2);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  // Edge detection
  logic prev_start, prev_stop, prev_load, prev_reset;
  logic press_start_q, press_stop_q, press_load_q, press_reset_q;

  // Long-press / auto-repeat counters
  logic [CNT_W-1:0] hold_cnt, hold_next;
  logic [CNT_W-1:0] rep_cnt, rep_next;

  logic [1:0] next_state;
  logic       load_next;
  logic       clear_next;
  logic       acted;

  // Press arbitration and state transitions. Priority reset > stop > start >
  // load; only the winner is considered, and a winner that the current state
  // ignores produces no action at all (the losers are simply dropped).
  always_comb begin
    next_state = state;
    load_next  = 1'b0;
    clear_next = 1'b0;
    acted      = 1'b0;
    if (press_reset_q) begin
      next_state = ST_IDLE;
      clear_next = 1'b1;
      acted      = 1'b1;
    end else if (press_stop_q) begin
      if (state == ST_RUN || state == ST_LOAD) begin
        next_state = ST_PAUSE;
        acted      = 1'b1;
      end
    end else if (press_start_q) begin
      if (state != ST_RUN) begin
        next_state = ST_RUN;
        acted      = 1'b1;
      end
    end else if (press_load_q) begin
      if (state != ST_RUN) begin
        next_state = ST_LOAD;
        load_next  = 1'b1;
        acted      = 1'b1;
      end
    end

    // Hold/repeat counters. Any acting press restarts them from 0, so the
    // edge that enters (or re-enters) LOAD is hold count 0. Releasing
    // btn_load clears them on the very next edge with no trailing strobe.
    hold_next = '0;
    rep_next  = '0;
    if (!acted && state == ST_LOAD && btn_load) begin
      if (hold_cnt == HOLD_LAST) begin
        hold_next = hold_cnt;
        if (rep_cnt == REP_LAST) begin
          rep_next  = '0;
          load_next = 1'b1;
        end else begin
          rep_next = rep_cnt + CNT_W'(1);
        end
      end else begin
        hold_next = hold_cnt + CNT_W'(1);
        // Reaching the long-press threshold fires the first repeat strobe;
        // the repeat counter starts from 0 on this same edge.
        if (hold_cnt == HOLD_PRE) begin
          load_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // Levels start "high" so a button held through reset is not a press.
      prev_start    <= 1'b1;
      prev_stop     <= 1'b1;
      prev_load     <= 1'b1;
      prev_reset    <= 1'b1;
      press_start_q <= 1'b0;
      press_stop_q  <= 1'b0;
      press_load_q  <= 1'b0;
      press_reset_q <= 1'b0;
      state         <= ST_IDLE;
      run           <= 1'b0;
      load_pulse    <= 1'b0;
      clear_pulse   <= 1'b0;
      hold_cnt      <= '0;
      rep_cnt       <= '0;
    end else begin
      prev_start    <= btn_start;
      prev_stop     <= btn_stop;
      prev_load     <= btn_load;
      prev_reset    <= btn_reset;
      press_start_q <= btn_start & ~prev_start;
      press_stop_q  <= btn_stop  & ~prev_stop;
      press_load_q  <= btn_load  & ~prev_load;
      press_reset_q <= btn_reset & ~prev_reset;
      state         <= next_state;
      run           <= (next_state == ST_RUN);
      load_pulse    <= load_next;
      clear_pulse   <= clear_next;
      hold_cnt      <= hold_next;
      rep_cnt       <= rep_next;
    end
  end

endmodule

// File: tb/tb_stopwatch_cmd_fsm.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_cmd_fsm
//
// Directed bench for stopwatch_cmd_fsm with LONG_PRESS_CYCLES=8 and
// REPEAT_CYCLES=4. Inputs are driven 1 ns after each rising edge and outputs
// are sampled at the same point, so each check sees the result of the edge
// just taken. Expected values are hand-derived from the press latency (press
// captured on edge k, FSM acts on edge k+1) and the hold/repeat timing:
// entry strobe at +2, first repeat at +9, then every 4 cycles while held.
// -----------------------------------------------------------------------------
module tb_stopwatch_cmd_fsm;

  logic       clk;
  logic       reset;
  logic       btn_start;
  logic       btn_stop;
  logic       btn_load;
  logic       btn_reset;
  logic       run;
  logic       load_pulse;
  logic       clear_pulse;
  logic [1:0] state;

  int check_cnt = 0;
  int error_cnt = 0;

  stopwatch_cmd_fsm #(
    .LONG_PRESS_CYCLES (8),
    .REPEAT_CYCLES     (4),
    .CNT_W             (26)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_start   (btn_start),
    .btn_stop    (btn_stop),
    .btn_load    (btn_load),
    .btn_reset   (btn_reset),
    .run         (run),
    .load_pulse  (load_pulse),
    .clear_pulse (clear_pulse),
    .state       (state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    check_cnt++;
    if (got !== exp) begin
      error_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [1:0] exp_state,
                               input logic exp_run, input logic exp_load,
                               input logic exp_clear);
    check_eq({tag, "_state"}, 32'(state), 32'(exp_state));
    check_eq({tag, "_run"},   32'(run),   32'(exp_run));
    check_eq({tag, "_load"},  32'(load_pulse),  32'(exp_load));
    check_eq({tag, "_clear"}, 32'(clear_pulse), 32'(exp_clear));
  endtask

  // Hold btn_load (already driven high by the caller) for n ticks, releasing
  // it after tick release_at; check load_pulse against the hand-computed tick
  // numbers p1..p4 (-1 = unused) and state after the entry edge.
  task automatic load_window(input string tag, input int n, input int release_at,
                             input int p1, input int p2, input int p3, input int p4);
    for (int i = 1; i <= n; i++) begin
      tick();
      check_eq($sformatf("%s_lp%0d", tag, i), 32'(load_pulse),
               32'((i == p1) || (i == p2) || (i == p3) || (i == p4)));
      if (i >= 2) check_eq($sformatf("%s_st%0d", tag, i), 32'(state), 32'd3);
      if (i == release_at) btn_load = 1'b0;
    end
  endtask

  initial begin
    reset     = 1'b1;
    btn_start = 1'b0;
    btn_stop  = 1'b0;
    btn_load  = 1'b0;
    btn_reset = 1'b0;
    repeat (3) tick();
    check_outputs("reset", 2'b00, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    tick();

    // Start pulse of 3 cycles: nothing after one edge, RUN after two.
    btn_start = 1'b1;
    tick();
    check_eq("start_latency_state", 32'(state), 32'd0);
    tick();
    check_outputs("start", 2'b01, 1'b1, 1'b0, 1'b0);
    tick();
    btn_start = 1'b0;
    tick();
    check_outputs("start_hold", 2'b01, 1'b1, 1'b0, 1'b0);

    // Stop from RUN -> PAUSE, then start 5 cycles after the stop rise.
    btn_stop = 1'b1;
    tick();
    tick();
    check_outputs("stop", 2'b10, 1'b0, 1'b0, 1'b0);
    tick();
    btn_stop = 1'b0;
    tick();
    tick();
    btn_start = 1'b1;
    tick();
    check_eq("resume_latency_state", 32'(state), 32'd2);
    tick();
    check_outputs("resume", 2'b01, 1'b1, 1'b0, 1'b0);
    btn_start = 1'b0;
    tick();

    // Reset, stop and start rising together in RUN: reset wins.
    btn_reset = 1'b1;
    btn_stop  = 1'b1;
    btn_start = 1'b1;
    tick();
    tick();
    check_outputs("multi_press", 2'b00, 1'b0, 1'b0, 1'b1);
    tick();
    check_outputs("multi_press_after", 2'b00, 1'b0, 1'b0, 1'b0);
    btn_reset = 1'b0;
    btn_stop  = 1'b0;
    btn_start = 1'b0;
    tick();

    // Stop is ignored in IDLE.
    btn_stop = 1'b1;
    repeat (3) tick();
    check_outputs("idle_stop", 2'b00, 1'b0, 1'b0, 1'b0);
    btn_stop = 1'b0;
    tick();

    // Long press from IDLE, held 20 cycles then released.
    btn_load = 1'b1;
    load_window("hold", 24, 20, 2, 9, 13, 17);
    check_outputs("hold_released", 2'b11, 1'b0, 1'b0, 1'b0);

    // Re-press load in LOAD, then reset during auto-repeat.
    btn_load = 1'b1;
    load_window("rep", 14, 0, 2, 9, 13, -1);
    reset    = 1'b1;
    btn_load = 1'b0;
    tick();
    check_outputs("mid_reset", 2'b00, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    tick();
    check_outputs("mid_reset_idle", 2'b00, 1'b0, 1'b0, 1'b0);

    // Hold count restarts from 0 after the reset.
    btn_load = 1'b1;
    load_window("relaod", 10, 10, 2, 9, -1, -1);
    tick();
    check_outputs("reload_released", 2'b11, 1'b0, 1'b0, 1'b0);

    // Start held through reset and released 10 cycles later: no event.
    reset     = 1'b1;
    btn_start = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    repeat (10) tick();
    check_outputs("held_start", 2'b00, 1'b0, 1'b0, 1'b0);
    btn_start = 1'b0;
    repeat (3) tick();
    check_outputs("held_start_released", 2'b00, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
    $finish;
  end

  // Strobes must never overlap.
  always @(negedge clk) begin
    if (!reset && load_pulse && clear_pulse) begin
      check_eq("strobe_overlap", 32'(load_pulse & clear_pulse), 32'd0);
    end
  end

endmodule
